// File: rtl/pc_generator_pkg.sv
// Shared definitions for the PC generator slice.
// Holds the default PC width, reset vector and return-address-stack depth
// used by pc_generator and return_address_stack, plus the nominal clock
// period used by benches.
package pc_generator_pkg;

   localparam int unsigned DEFAULT_XLEN         = 32;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned DEFAULT_RAS_DEPTH    = 4;
   localparam int unsigned CLOCK_PERIOD         = 10;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack.
// Ports:
//   CLK, RST_N   - clock, asynchronous active-low reset
//   push_i       - push data_i on top (overwrites oldest entry when full)
//   pop_i        - remove top entry (ignored when empty)
//   data_i       - value to push
//   top_o        - current top entry (only meaningful when count_o > 0)
//   count_o      - number of valid entries, saturating at Depth
// push_i and pop_i together on a non-empty stack replace the top in place.
module return_address_stack
   import pc_generator_pkg::*;
#(
   parameter int unsigned Width = DEFAULT_XLEN,
   parameter int unsigned Depth = DEFAULT_RAS_DEPTH
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [Width-1:0]           data_i,
   output logic [Width-1:0]           top_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth+1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  sp_q, sp_d, top_idx, wr_idx;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             wr_en;
   logic             empty;

   // sp_q points at the next free slot; Depth is a power of two so the
   // pointer wraps naturally, and when full it points at the oldest entry.
   assign top_idx = sp_q - PtrW'(1);
   assign empty   = (cnt_q == '0);

   always_comb begin
      sp_d   = sp_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = sp_q;
      if (push_i && pop_i && !empty) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push_i) begin
         wr_en = 1'b1;
         sp_d  = sp_q + PtrW'(1);
         if (cnt_q != CntW'(Depth)) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop_i && !empty) begin
         sp_d  = top_idx;
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

   // Entries are never cleared: a zero count makes stale data unreachable.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_idx] <= data_i;
      end
   end

   assign top_o   = mem_q[top_idx];
   assign count_o = cnt_q;

endmodule

// File: rtl/pc_generator.sv
// Fetch program-counter generator with prioritised redirects and a
// return-address stack for call/return prediction.
// Ports:
//   CLK, RST_N      - clock, asynchronous active-low reset
//   PC_En           - 1 = advance, 0 = stall
//   Redirect_Valid  - per-channel redirect request, index 0 wins
//   Redirect_Target - per-channel redirect address (bit 0 dropped on load)
//   Call_Push       - current PC is a call; push PC_Out+4
//   Ret_Pop         - current PC is a return; predict from stack top
//   PC_Out          - registered current PC
//   PC_Plus4_Out    - PC_Out+4 (combinational)
//   Ras_Count       - valid return-address-stack entries
module pc_generator
   import pc_generator_pkg::*;
#(
   parameter int unsigned     XLEN         = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int unsigned     NUM_REDIRECT = 2,
   parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
   input  logic                                CLK,
   input  logic                                RST_N,
   input  logic                                PC_En,
   input  logic [NUM_REDIRECT-1:0]             Redirect_Valid,
   input  logic [NUM_REDIRECT-1:0][XLEN-1:0]   Redirect_Target,
   input  logic                                Call_Push,
   input  logic                                Ret_Pop,
   output logic [XLEN-1:0]                     PC_Out,
   output logic [XLEN-1:0]                     PC_Plus4_Out,
   output logic [$clog2(RAS_DEPTH+1)-1:0]      Ras_Count
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] ras_top;
   logic            redirect_any;
   logic            advance;
   logic            ras_push, ras_pop;

   // Walk from highest to lowest index so the lowest asserted channel wins.
   always_comb begin
      redirect_any = 1'b0;
      redirect_pc  = '0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         if (Redirect_Valid[i]) begin
            redirect_any = 1'b1;
            redirect_pc  = Redirect_Target[i] & ~XLEN'(1);
         end
      end
   end

   assign pc_plus4 = pc_q + XLEN'(4);

   // Stack operations only take effect on a genuine sequential advance.
   assign advance  = PC_En && !redirect_any;
   assign ras_push = advance && Call_Push;
   assign ras_pop  = advance && Ret_Pop;

   always_comb begin
      pc_d = pc_plus4;
      if (redirect_any) begin
         pc_d = redirect_pc;
      end else if (!PC_En) begin
         pc_d = pc_q;
      end else if (Ret_Pop && (Ras_Count != '0)) begin
         pc_d = ras_top;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   return_address_stack #(
      .Width (XLEN),
      .Depth (RAS_DEPTH)
   ) u_ras (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (pc_plus4),
      .top_o   (ras_top),
      .count_o (Ras_Count)
   );

   assign PC_Out       = pc_q;
   assign PC_Plus4_Out = pc_plus4;

`ifndef SYNTHESIS
   stall_holds_pc: assert property (@(posedge CLK) disable iff (!RST_N)
      (!PC_En && !redirect_any) |=> $stable(PC_Out));

   redirect_loads_target: assert property (@(posedge CLK) disable iff (!RST_N)
      redirect_any |=> (PC_Out == $past(redirect_pc)));

   ras_count_bounded: assert property (@(posedge CLK) disable iff (!RST_N)
      Ras_Count <= ($clog2(RAS_DEPTH+1))'(RAS_DEPTH));
`endif

endmodule

// File: tb/tb_pc_generator.sv
module tb_pc_generator;
   import pc_generator_pkg::*;

   typedef struct {
      logic [31:0] pc;
      int          cnt;
      string       name;
   } exp_t;

   logic              CLK;
   logic              RST_N;
   logic              PC_En;
   logic [1:0]        Redirect_Valid;
   logic [1:0][31:0]  Redirect_Target;
   logic              Call_Push;
   logic              Ret_Pop;
   logic [31:0]       PC_Out;
   logic [31:0]       PC_Plus4_Out;
   logic [2:0]        Ras_Count;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pc_generator #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .NUM_REDIRECT (2),
      .RAS_DEPTH    (4)
   ) dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .PC_En           (PC_En),
      .Redirect_Valid  (Redirect_Valid),
      .Redirect_Target (Redirect_Target),
      .Call_Push       (Call_Push),
      .Ret_Pop         (Ret_Pop),
      .PC_Out          (PC_Out),
      .PC_Plus4_Out    (PC_Plus4_Out),
      .Ras_Count       (Ras_Count)
   );

   initial begin
      CLK = 1'b0;
      forever #(CLOCK_PERIOD / 2) CLK = ~CLK;
   end

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      PC_En           = 1'b0;
      Redirect_Valid  = 2'b00;
      Redirect_Target = '0;
      Call_Push       = 1'b0;
      Ret_Pop         = 1'b0;
   endtask

   // Drive one cycle of stimulus and queue the expected post-edge state.
   task automatic step(input logic en, input logic [1:0] rv, input logic [31:0] t0,
                       input logic [31:0] t1, input logic push, input logic pop,
                       input logic [31:0] exp_pc, input int exp_cnt, input string name);
      exp_t e;
      @(negedge CLK);
      PC_En              = en;
      Redirect_Valid     = rv;
      Redirect_Target[0] = t0;
      Redirect_Target[1] = t1;
      Call_Push          = push;
      Ret_Pop            = pop;
      e.pc   = exp_pc;
      e.cnt  = exp_cnt;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: the PC updates every edge, so any pending expectation is due.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.name, " pc"}, PC_Out, e.pc);
            check_val({e.name, " pc+4"}, PC_Plus4_Out, e.pc + 32'd4);
            check_val({e.name, " count"}, {29'b0, Ras_Count}, e.cnt[31:0]);
         end
      end
   end

   initial begin
      int wait_cycles;
      idle_inputs();
      RST_N = 1'b0;
      #1;
      check_val("reset pc", PC_Out, 32'h0);
      check_val("reset count", {29'b0, Ras_Count}, 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check_val("post-reset pc", PC_Out, 32'h0);

      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 0, "inc1");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 0, "inc2");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'hC, 0, "inc3");

      // Asynchronous reset mid-run, checked before any further edge.
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check_val("midrun reset pc", PC_Out, 32'h0);
      idle_inputs();
      @(negedge CLK);
      RST_N = 1'b1;

      step(1'b1, 2'b01, 32'h40, 32'h0, 1'b0, 1'b0, 32'h40, 0, "redir40");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 0, "stall");
      end
      step(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, "redir_top");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, "wrap");
      step(1'b0, 2'b01, 32'h101, 32'h0, 1'b0, 1'b0, 32'h100, 0, "redir_stall");
      step(1'b1, 2'b11, 32'h200, 32'h300, 1'b1, 1'b0, 32'h200, 0, "priority");
      step(1'b1, 2'b10, 32'h0, 32'h303, 1'b0, 1'b0, 32'h302, 0, "chan1");

      // Call / return.
      step(1'b1, 2'b01, 32'h10, 32'h0, 1'b0, 1'b0, 32'h10, 0, "redir10");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 1, "call");
      step(1'b1, 2'b01, 32'h80, 32'h0, 1'b0, 1'b1, 32'h80, 1, "redir80_pop_ign");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h14, 0, "ret");

      // Stack boundaries: fill past depth, drain, then pop when empty.
      step(1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, "redir0");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 1, "push1");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 2, "push2");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'hC, 3, "push3");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 4, "push4");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 4, "push5_full");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h14, 3, "pop1");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 2, "pop2");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC, 1, "pop3");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8, 0, "pop4");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC, 0, "pop_empty");

      // Simultaneous push/pop, and stall masking stack operations.
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 1, "push_c");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 1, "pushpop");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h14, 0, "pop_replaced");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h18, 1, "pushpop_empty");
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h18, 1, "stall_ignore");
      step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h18, 0, "pop_last");

      @(negedge CLK);
      idle_inputs();
      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 10) begin
         @(negedge CLK);
         wait_cycles++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations pending, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
